// File: rtl/mem_pkg.sv
// ---------------------------------------------------------------------------
// mem_pkg
// Shared definitions for the memory-bus masters: bus widths, the command RAM
// window and the command uploader state encoding.
// No ports (package).
// ---------------------------------------------------------------------------
package mem_pkg;

  localparam int unsigned MEM_ADDR_W  = 22;
  localparam int unsigned CMD_W       = 32;
  localparam int unsigned WINDOW_W    = 10;
  localparam int unsigned WORD_OFF_W  = 12;
  localparam int unsigned LOAD_CNT_W  = 13;

  // Command RAM lives at address[21:12] == 10'h100.
  localparam logic [WINDOW_W-1:0] COMMAND_WINDOW = 10'h100;

  typedef enum logic [1:0] {
    UPL_IDLE = 2'd0,
    UPL_RUN  = 2'd1,
    UPL_DONE = 2'd2
  } upl_state_e;

  // Full bus address from the window select and the word offset inside it.
  function automatic logic [MEM_ADDR_W-1:0] cmd_addr(
    input logic [WINDOW_W-1:0]   window,
    input logic [WORD_OFF_W-1:0] offset
  );
    return {window, offset};
  endfunction

endpackage

// File: rtl/mem_interface.sv
// ---------------------------------------------------------------------------
// mem_interface
// Single-word memory bus between a master and mem_interface.
// Signals:
//   request       master holds high while a transaction is outstanding
//   address       22-bit word address
//   data_write    32-bit write data
//   write_enable  1 = write transaction
//   last4         burst marker (unused by single-word masters)
//   ready         slave completes the transaction on the cycle it is high
// ---------------------------------------------------------------------------
interface mem_interface;
  import mem_pkg::*;

  logic                  request;
  logic [MEM_ADDR_W-1:0] address;
  logic [CMD_W-1:0]      data_write;
  logic                  write_enable;
  logic                  last4;
  logic                  ready;

  modport master (
    output request,
    output address,
    output data_write,
    output write_enable,
    output last4,
    input  ready
  );

  modport slave (
    input  request,
    input  address,
    input  data_write,
    input  write_enable,
    input  last4,
    output ready
  );

endinterface

// File: rtl/sync_fifo.sv
// ---------------------------------------------------------------------------
// sync_fifo
// Single-clock FIFO with first-word-fall-through head output.
// DEPTH must be a power of two (>= 2) so the pointers wrap naturally.
// Ports:
//   clock, reset   clock and synchronous active-high reset (empties FIFO)
//   push/push_data write one entry; ignored when full
//   pop            discard the head entry; ignored when empty
//   head           oldest entry (valid when !empty)
//   full, empty    occupancy flags
// ---------------------------------------------------------------------------
module sync_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE    = PTR_W'(1);
  localparam logic [PTR_W:0]   CNT_ONE    = (PTR_W + 1)'(1);
  localparam logic [PTR_W:0]   CNT_ZERO   = (PTR_W + 1)'(0);
  localparam logic [PTR_W:0]   FULL_COUNT = (PTR_W + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             push_ok_s;
  logic             pop_ok_s;

  // Qualified push/pop, next pointers and occupancy.
  always_comb begin
    push_ok_s = push && (count_q != FULL_COUNT);
    pop_ok_s  = pop && (count_q != CNT_ZERO);

    if (push_ok_s) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    if (pop_ok_s) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    // Push and pop together leave occupancy unchanged.
    case ({push_ok_s, pop_ok_s})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= CNT_ZERO;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents need no reset because occupancy guards reads.
  always_ff @(posedge clock) begin
    if (push_ok_s) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

  assign head  = mem_q[rd_ptr_q];
  assign full  = (count_q == FULL_COUNT);
  assign empty = (count_q == CNT_ZERO);

endmodule

// File: rtl/command_uploader.sv
// ---------------------------------------------------------------------------
// command_uploader
// Bus master that streams 32-bit command words into the command RAM window.
// Words from the source are buffered in a sync_fifo; each buffered word is
// written with its own single-word transaction at {WINDOW, wr_idx}, wr_idx
// counting up from load_base modulo 4096.
// Ports:
//   clock, reset  clock and synchronous active-high reset
//   load_start    pulse starting an upload (ignored unless idle)
//   load_base     first 12-bit word offset, sampled on load_start
//   load_count    number of words (0..4096), sampled on load_start
//   word_valid    source offers word_data
//   word_data     command word
//   word_ready    uploader accepts word_data this cycle
//   busy          upload in progress
//   done          one-cycle completion pulse
//   mem_bus       memory bus master port
// ---------------------------------------------------------------------------
module command_uploader
  import mem_pkg::*;
#(
  parameter int unsigned         FIFO_DEPTH = 4,
  parameter logic [WINDOW_W-1:0] WINDOW     = COMMAND_WINDOW
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  load_start,
  input  logic [WORD_OFF_W-1:0] load_base,
  input  logic [LOAD_CNT_W-1:0] load_count,
  input  logic                  word_valid,
  input  logic [CMD_W-1:0]      word_data,
  output logic                  word_ready,
  output logic                  busy,
  output logic                  done,
  mem_interface.master          mem_bus
);

  upl_state_e            state_q, state_d;
  logic [WORD_OFF_W-1:0] wr_idx_q, wr_idx_d;
  logic [LOAD_CNT_W-1:0] remaining_q, remaining_d;
  logic [LOAD_CNT_W-1:0] accepted_q, accepted_d;
  logic [LOAD_CNT_W-1:0] count_q, count_d;
  logic                  request_q, request_d;
  logic                  write_enable_q, write_enable_d;
  logic [MEM_ADDR_W-1:0] address_q, address_d;
  logic [CMD_W-1:0]      data_write_q, data_write_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;

  logic                  word_ready_s;
  logic                  push_s;
  logic                  write_done_s;
  logic                  fifo_full_s;
  logic                  fifo_empty_s;
  logic [CMD_W-1:0]      fifo_head_s;

  sync_fifo #(
    .WIDTH (CMD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (push_s),
    .push_data (word_data),
    .pop       (write_done_s),
    .head      (fifo_head_s),
    .full      (fifo_full_s),
    .empty     (fifo_empty_s)
  );

  // Source-side acceptance: only while running, with room, and until the
  // requested number of words has been taken.
  always_comb begin
    if (state_q == UPL_RUN) begin
      word_ready_s = !fifo_full_s && (accepted_q < count_q);
    end else begin
      word_ready_s = 1'b0;
    end
    push_s       = word_valid && word_ready_s;
    write_done_s = request_q && mem_bus.ready;
  end

  // Upload sequencing and bus request generation.
  always_comb begin
    state_d        = state_q;
    wr_idx_d       = wr_idx_q;
    remaining_d    = remaining_q;
    accepted_d     = accepted_q;
    count_d        = count_q;
    request_d      = request_q;
    write_enable_d = write_enable_q;
    address_d      = address_q;
    data_write_d   = data_write_q;

    case (state_q)
      UPL_IDLE: begin
        request_d      = 1'b0;
        write_enable_d = 1'b0;
        if (load_start) begin
          wr_idx_d    = load_base;
          remaining_d = load_count;
          count_d     = load_count;
          accepted_d  = 13'd0;
          if (load_count == 13'd0) begin
            state_d = UPL_DONE;
          end else begin
            state_d = UPL_RUN;
          end
        end else begin
          state_d = UPL_IDLE;
        end
      end

      UPL_RUN: begin
        if (push_s) begin
          accepted_d = accepted_q + 13'd1;
        end else begin
          accepted_d = accepted_q;
        end

        if (write_done_s) begin
          // Request always drops for a cycle after completion; a queued
          // word is picked up by the issue branch on the following cycle.
          request_d      = 1'b0;
          write_enable_d = 1'b0;
          wr_idx_d       = wr_idx_q + 12'd1;
          remaining_d    = remaining_q - 13'd1;
          if (remaining_q == 13'd1) begin
            state_d = UPL_DONE;
          end else begin
            state_d = UPL_RUN;
          end
        end else if (!request_q && !fifo_empty_s) begin
          request_d      = 1'b1;
          write_enable_d = 1'b1;
          address_d      = cmd_addr(WINDOW, wr_idx_q);
          data_write_d   = fifo_head_s;
        end else begin
          // Outstanding request: hold address/data until ready.
          request_d      = request_q;
          write_enable_d = write_enable_q;
        end
      end

      UPL_DONE: begin
        request_d      = 1'b0;
        write_enable_d = 1'b0;
        state_d        = UPL_IDLE;
      end

      default: begin
        request_d      = 1'b0;
        write_enable_d = 1'b0;
        state_d        = UPL_IDLE;
      end
    endcase

    busy_d = (state_d == UPL_RUN);
    done_d = (state_d == UPL_DONE);
  end

  // State and output registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q        <= UPL_IDLE;
      wr_idx_q       <= 12'd0;
      remaining_q    <= 13'd0;
      accepted_q     <= 13'd0;
      count_q        <= 13'd0;
      request_q      <= 1'b0;
      write_enable_q <= 1'b0;
      address_q      <= 22'd0;
      data_write_q   <= 32'd0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      wr_idx_q       <= wr_idx_d;
      remaining_q    <= remaining_d;
      accepted_q     <= accepted_d;
      count_q        <= count_d;
      request_q      <= request_d;
      write_enable_q <= write_enable_d;
      address_q      <= address_d;
      data_write_q   <= data_write_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
    end
  end

  assign word_ready           = word_ready_s;
  assign busy                 = busy_q;
  assign done                 = done_q;
  assign mem_bus.request      = request_q;
  assign mem_bus.write_enable = write_enable_q;
  assign mem_bus.address      = address_q;
  assign mem_bus.data_write   = data_write_q;
  assign mem_bus.last4        = 1'b0;

endmodule
